// File: rtl/fetch_pkg.sv
// Shared constants for the MIPS fetch stage: FSM encoding, PC step and bubble word.
// Imported by instruction_fetch_unit and if_id_register.
package fetch_pkg;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id.sv
// IF/ID pipeline register: flush inserts a bubble, load captures a fetch,
// hold (or no request) keeps the current contents.
module if_id_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic        hold,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush) begin
      instr_d    = NOP_WORD;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (load && !hold) begin
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_WORD;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_plus4_out = pc_plus4_q;
  assign valid_out    = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC and boot/run/halt FSM, drives the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds FetchCount/BubbleCount performance counters.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Halt,
  input  logic        Resume,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        Halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  state_q, state_d;
  logic        ifid_load, ifid_flush, ifid_hold;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + PC_STEP;

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      S_BOOT: begin
        if (Halt) begin
          ifid_flush = 1'b1;
          state_d    = S_HALT;
        end else begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (BranchTaken) begin
          ifid_flush = 1'b1;
          pc_d       = align_word(BranchTarget);
        end else if (Halt) begin
          ifid_flush = 1'b1;
          state_d    = S_HALT;
        end else if (!Stall) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
        end
      end
      S_HALT: begin
        // A branch resolving while halted must not be lost; it also defers resume.
        ifid_flush = 1'b1;
        if (BranchTaken) begin
          pc_d = align_word(BranchTarget);
        end else if (Resume && !Halt) begin
          state_d = S_RUN;
        end
      end
      default: begin
        ifid_flush = 1'b1;
        state_d    = S_BOOT;
      end
    endcase
  end

  assign ifid_hold = !ifid_load && !ifid_flush;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_q    <= PC_RESET;
      state_q <= S_BOOT;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  if_id_register #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .load        (ifid_load),
    .flush       (ifid_flush),
    .hold        (ifid_hold),
    .instr_in    (IMemInstruction),
    .pc_plus4_in (pc_plus4),
    .instr_out   (IFID_Instruction),
    .pc_plus4_out(IFID_PCPlus4),
    .valid_out   (IFID_Valid)
  );

  assign IMemAddress = pc_q;
  assign Halted      = (state_q == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'd0, ifid_load};
    bubble_cnt_d = bubble_cnt_q + {31'd0, ifid_flush};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign FetchCount  = fetch_cnt_q;
  assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: stimulus pushes expected IF/ID and PC
// state per edge from a behavioural model; a monitor pops and compares after each edge.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        stall, branch_taken, halt, resume;
  logic [31:0] branch_target;
  logic [31:0] ifid_instruction, ifid_pc_plus4;
  logic        ifid_valid, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, bubble_count;
`endif

  logic [31:0] mem [128];
  assign imem_instruction = mem[imem_address[8:2]];

  instruction_fetch_unit dut (
    .Clk             (clk),
    .Rst_n           (rst_n),
    .IMemAddress     (imem_address),
    .IMemInstruction (imem_instruction),
    .Stall           (stall),
    .BranchTaken     (branch_taken),
    .BranchTarget    (branch_target),
    .Halt            (halt),
    .Resume          (resume),
    .IFID_Instruction(ifid_instruction),
    .IFID_PCPlus4    (ifid_pc_plus4),
    .IFID_Valid      (ifid_valid),
    .Halted          (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount      (fetch_count),
    .BubbleCount     (bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model: where fetch points, what decode currently sees, and
  // whether we are in the boot cycle or parked.
  logic [31:0] m_pc, m_instr, m_pcp4;
  logic        m_valid, m_halted, m_boot;
  int unsigned m_fetches, m_bubbles;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_boot = 1'b1;
    m_fetches = 0; m_bubbles = 0;
  endtask

  task automatic issue();
    m_instr = mem[m_pc[8:2]];
    m_pcp4  = m_pc + 32'd4;
    m_valid = 1'b1;
    m_pc    = m_pc + 32'd4;
    m_fetches++;
  endtask

  task automatic bubble();
    m_instr = 32'h0;
    m_valid = 1'b0;
    m_bubbles++;
  endtask

  // Called in the clock-low phase: drive one cycle of inputs, predict the
  // post-edge state, then wait for the following negedge.
  task automatic cycle(input logic s, input logic br, input logic [31:0] tgt,
                       input logic h, input logic r);
    stall = s; branch_taken = br; branch_target = tgt; halt = h; resume = r;
    #1;
    check("imem_addr_pre", imem_address, m_pc);
    if (m_boot) begin
      m_boot = 1'b0;
      if (h) begin bubble(); m_halted = 1'b1; end
      else issue();
    end else if (m_halted) begin
      bubble();
      if (br) m_pc = {tgt[31:2], 2'b00};
      else if (r && !h) m_halted = 1'b0;
    end else if (br) begin
      bubble();
      m_pc = {tgt[31:2], 2'b00};
    end else if (h) begin
      bubble();
      m_halted = 1'b1;
    end else if (!s) begin
      issue();
    end
    exp_q.push_back('{pc: m_pc, instr: m_instr, pcp4: m_pcp4, valid: m_valid, halted: m_halted});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic run_to(input logic [31:0] addr);
    int guard = 0;
    while (m_pc != addr && guard < 200) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      guard++;
    end
    check("run_to_reached", m_pc, addr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, imem_address, 32'h0);
    check({tag, "_instr"}, ifid_instruction, 32'h0);
    check({tag, "_pcp4"}, ifid_pc_plus4, 32'h0);
    check({tag, "_valid"}, {31'd0, ifid_valid}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  // Asynchronous reset pulse between edges; entered and left in the low phase.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(posedge clk); #1;
    check_reset_outputs("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: compare DUT state shortly after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", imem_address, e.pc);
        check("ifid_instr", ifid_instruction, e.instr);
        check("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
        check("halted", {31'd0, halted}, {31'd0, e.halted});
        if (e.valid) check("ifid_pcp4", ifid_pc_plus4, e.pcp4);
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = i * 3;
    rst_n = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; halt = 1'b0; resume = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Boot plus free-running fetch.
    idle(4);
    run_to(32'h20);
    // Stall holds PC and IF/ID, then fetch resumes at word 8.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1);
    // Backward branch to word 1.
    run_to(32'h64);
    cycle(1'b0, 1'b1, 32'h04, 1'b0, 1'b0);
    idle(2);
    // Redirect wins over a simultaneous stall.
    cycle(1'b1, 1'b1, 32'h1C, 1'b0, 1'b0);
    idle(1);
    // Halt at 0x10, stall ignored, halt+resume stays halted, resume restarts.
    cycle(1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(2);
    // Branch while halted updates PC but stays halted.
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h43, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(2);
    // PC wraps modulo 2^32; low target bits ignored.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    idle(2);

    // Async reset mid-run, normal reboot.
    async_reset();
    idle(3);
    // Async reset then halt during the boot cycle.
    async_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(3);

    // Randomized traffic against random memory contents.
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : {23'd0, 9'($urandom)};
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, tgt,
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
    end

    @(posedge clk); #2;
    check("scoreboard_drained", exp_q.size(), 0);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, m_fetches);
    check("bubble_count", bubble_count, m_bubbles);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the 5-stage MIPS pipeline. Owns the program counter and the IF/ID pipeline register.
- Drives the word address into the combinational instruction memory and captures the returned instruction together with PC+4.
- Honours decode-stage stall, taken-branch/jump redirect and a halt/resume control.
- Inserts nop bubbles (32'h0000_0000) wherever no valid instruction is issued.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, encoding placed in IF/ID for a bubble.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous, active-low reset.
- IMemAddress  out  32  current PC; the instruction memory indexes with bits [8:2].
- IMemInstruction  in  32  instruction read combinationally at IMemAddress.
- Stall  in  1  hold PC and IF/ID (load-use/hazard stall from decode).
- BranchTaken  in  1  redirect request, valid this cycle.
- BranchTarget  in  32  redirect target; bits [1:0] are ignored.
- Halt  in  1  request to stop fetching.
- Resume  in  1  request to restart fetching.
- IFID_Instruction  out  32  instruction presented to decode.
- IFID_PCPlus4  out  32  PC+4 of that instruction.
- IFID_Valid  out  1  1 = real instruction, 0 = bubble.
- Halted  out  1  1 while in S_HALT.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - PC = PC_RESET, IFID_Instruction = NOP_WORD, IFID_PCPlus4 = 0, IFID_Valid = 0, Halted = 0.
  - FSM enters S_BOOT. Reset asserted mid-operation discards all in-flight state immediately.
- IMemAddress = PC, purely from the register, with no combinational path from inputs.
- Latency: the instruction at PC appears on IFID_* one clock after PC is presented.
- FSM states and transitions:
  - S_BOOT: single cycle after reset release. IF/ID is loaded with IMemInstruction at PC_RESET, Valid = 1, PC += 4. Transitions to S_RUN, unless Halt = 1, in which case it goes to S_HALT, PC stays at PC_RESET and IF/ID loads a bubble.
  - S_RUN: normal fetch, using the per-edge priority below.
  - S_HALT: PC frozen; IF/ID loads a bubble every cycle; Halted = 1. Resume = 1 with Halt = 0 moves to S_RUN at the next edge, with the first fetch in the cycle after. If Halt and Resume are both 1, Halt wins and the FSM stays in S_HALT.
- Per-edge priority in S_RUN (highest first):
  1. BranchTaken = 1: PC <= {BranchTarget[31:2], 2'b00}; IF/ID <= bubble (flushes the wrong-path fetch). Redirect wins over a simultaneous Stall.
  2. Halt = 1: PC held; IF/ID <= bubble; go to S_HALT.
  3. Stall = 1: PC and all IFID_* outputs hold their values.
  4. Otherwise: IFID_Instruction <= IMemInstruction, IFID_PCPlus4 <= PC+4, IFID_Valid <= 1, PC <= PC+4.
- In S_HALT, BranchTaken still updates PC (so an in-flight branch is not lost); the FSM stays in S_HALT and IF/ID stays a bubble.
- Arithmetic: PC+4 is a 32-bit add that wraps modulo 2^32 with no flag. Memory aliasing beyond 128 words is the instruction memory's concern; this block does not clamp.
- Stall in S_BOOT or S_HALT is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs FetchCount (32) and BubbleCount (32). Both reset to 0 and increment on each edge where IF/ID loads a valid instruction or a bubble respectively; stall cycles count neither. Both wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - FSM state encoding S_BOOT = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2.
  - Constant PC_STEP = 4.
  - Constant NOP_WORD default.
- One natural sub-module: if_id_register. It takes load, flush and hold controls and holds Instruction, PCPlus4 and Valid. The PC register and FSM remain in the top module.

Test Plan:
- Reset then 4 free-running clocks with memory word i = i*3 → IMemAddress = 0,4,8,12,16; IFID_Instruction = 0,3,6,9; IFID_PCPlus4 = 4,8,12,16; Valid = 1 from the first post-boot edge.
- Stall high for 3 cycles at PC = 0x20 → PC stays 0x20 and IFID_* stay unchanged for 3 edges; fetch resumes with word 8 (value 24).
- BranchTaken with target 0x04 while PC = 0x64 (backward loop to word 1) → next IMemAddress = 0x04, IFID_Valid = 0, IFID_Instruction = 0; the following edge yields word 1.
- BranchTaken = 1 and Stall = 1 on the same edge with target 0x1C → PC = 0x1C and a bubble is inserted (redirect wins).
- Halt at PC = 0x10 → Halted = 1, bubbles every cycle, PC = 0x10. Halt and Resume together → still halted. Resume alone → Halted = 0 next edge, then word 4 fetched.
- Rst_n pulsed low asynchronously between edges mid-run → outputs immediately show PC = 0, Valid = 0, NOP. The boot sequence repeats after release.
